// File: rtl/cu_pkg.sv
// Shared control-unit package: memory responder state encoding and default widths.
package cu_pkg;
   localparam int ADDR_W_DEF = 5;
   localparam int DATA_W_DEF = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      ACK  = 2'd2
   } mem_state_t;
endpackage

// File: rtl/ram_array.sv
// Word array with one synchronous write port and a registered read port; no reset.
module ram_array #(
   parameter int ADDR_W = 5,
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic              re,
   input  logic [ADDR_W-1:0] raddr,
   output logic [DATA_W-1:0] rdata
);
   logic [DATA_W-1:0] mem [2**ADDR_W];

   // Write-first on a same-address read so a write access returns the new word.
   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
      if (re) rdata <= (we && (waddr == raddr)) ? wdata : mem[raddr];
   end
endmodule

// File: rtl/mem_responder.sv
// Req/Ack memory responder with programmable wait states and an idle-only load port.
//
// state | meaning
// IDLE  | no access; LoadWr writes, else Req is latched
// WAIT  | wait-state down-counter running toward terminal count 0
// ACK   | access done; Ack high, RData held until Req drops
module mem_responder
   import cu_pkg::*;
#(
   parameter int ADDR_W      = ADDR_W_DEF,
   parameter int DATA_W      = DATA_W_DEF,
   parameter int WAIT_CYCLES = 1
) (
   input  logic              Clk,
   input  logic              Reset,
   input  logic              Req,
   input  logic              Wr,
   input  logic [ADDR_W-1:0] Addr,
   input  logic [DATA_W-1:0] WData,
   output logic [DATA_W-1:0] RData,
   output logic              Ack,
   output logic              Busy,
   input  logic              LoadWr,
   input  logic [ADDR_W-1:0] LoadAddr,
   input  logic [DATA_W-1:0] LoadData,
   output logic              LoadDrop
);
   localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

   mem_state_t        state_q, state_d;
   logic [3:0]        cnt_q, cnt_d;
   logic              lat_wr_q;
   logic [ADDR_W-1:0] lat_addr_q;
   logic [DATA_W-1:0] lat_data_q;
   logic              drop_q;

   logic              lat_load, enter_ack;
   logic              acc_wr;
   logic [ADDR_W-1:0] acc_addr;
   logic [DATA_W-1:0] acc_data;
   logic              ram_we, ram_re;
   logic [ADDR_W-1:0] ram_waddr;
   logic [DATA_W-1:0] ram_wdata;
   logic [DATA_W-1:0] ram_rdata;

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         lat_wr_q   <= 1'b0;
         lat_addr_q <= '0;
         lat_data_q <= '0;
         drop_q     <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         drop_q  <= LoadWr && (state_q != IDLE);
         if (lat_load) begin
            lat_wr_q   <= Wr;
            lat_addr_q <= Addr;
            lat_data_q <= WData;
         end
      end
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      lat_load  = 1'b0;
      enter_ack = 1'b0;
      acc_wr    = lat_wr_q;
      acc_addr  = lat_addr_q;
      acc_data  = lat_data_q;
      ram_we    = 1'b0;
      ram_waddr = lat_addr_q;
      ram_wdata = lat_data_q;
      ram_re    = 1'b0;

      case (state_q)
         IDLE: begin
            if (LoadWr) begin
               ram_we    = 1'b1;
               ram_waddr = LoadAddr;
               ram_wdata = LoadData;
            end else if (Req) begin
               lat_load = 1'b1;
               // With no wait states the access completes on the sampling edge itself.
               acc_wr   = Wr;
               acc_addr = Addr;
               acc_data = WData;
               if (WAIT_CYCLES == 0) begin
                  state_d   = ACK;
                  enter_ack = 1'b1;
               end else begin
                  state_d = WAIT;
                  cnt_d   = WAIT_LOAD;
               end
            end
         end
         WAIT: begin
            if (cnt_q == 4'd0) begin
               state_d   = ACK;
               enter_ack = 1'b1;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         ACK: begin
            if (!Req) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      if (enter_ack) begin
         ram_we    = acc_wr;
         ram_waddr = acc_addr;
         ram_wdata = acc_data;
         ram_re    = 1'b1;
      end
   end

   ram_array #(
      .ADDR_W(ADDR_W),
      .DATA_W(DATA_W)
   ) u_ram (
      .clk  (Clk),
      .we   (ram_we),
      .waddr(ram_waddr),
      .wdata(ram_wdata),
      .re   (ram_re),
      .raddr(acc_addr),
      .rdata(ram_rdata)
   );

   // The array read register has no reset, so RData is qualified by the ACK state.
   assign RData    = (state_q == ACK) ? ram_rdata : '0;
   assign Ack      = (state_q == ACK);
   assign Busy     = (state_q != IDLE);
   assign LoadDrop = drop_q;
endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: three instances (1, 0 and 3 wait states) against a cycle-count model.
module tb_mem_responder;
   localparam int N = 3;

   logic       clk, rst;
   logic       req    [N];
   logic       wr     [N];
   logic [4:0] addr   [N];
   logic [7:0] wdata  [N];
   logic [7:0] rdata  [N];
   logic       ack    [N];
   logic       busy   [N];
   logic       ldwr   [N];
   logic [4:0] ldaddr [N];
   logic [7:0] lddata [N];
   logic       drop   [N];

   int n_vec = 0;
   int n_err = 0;
   bit checking = 0;

   function automatic int wc(input int i);
      return (i == 0) ? 1 : (i == 1) ? 0 : 3;
   endfunction

   for (genvar g = 0; g < N; g++) begin : g_dut
      mem_responder #(
         .ADDR_W(5),
         .DATA_W(8),
         .WAIT_CYCLES((g == 0) ? 1 : (g == 1) ? 0 : 3)
      ) u_dut (
         .Clk     (clk),
         .Reset   (rst),
         .Req     (req[g]),
         .Wr      (wr[g]),
         .Addr    (addr[g]),
         .WData   (wdata[g]),
         .RData   (rdata[g]),
         .Ack     (ack[g]),
         .Busy    (busy[g]),
         .LoadWr  (ldwr[g]),
         .LoadAddr(ldaddr[g]),
         .LoadData(lddata[g]),
         .LoadDrop(drop[g])
      );
   end

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input int i, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s inst%0d: got %0h, expected %0h at %0t", name, i, act, exp, $time);
      end
   endtask

   // Model: an access is a countdown of edges from the sampling edge; completion happens when it hits zero.
   bit [7:0] m_mem   [N][32];
   bit       m_known [N][32];
   bit       m_pend  [N];
   bit       m_ack   [N];
   bit       m_drop  [N];
   int       m_left  [N];
   bit       m_wr    [N];
   bit [4:0] m_addr  [N];
   bit [7:0] m_data  [N];
   bit [7:0] m_rdata [N];
   bit       m_rknown[N];

   task automatic m_complete(input int i);
      m_pend[i] = 0;
      m_ack[i]  = 1;
      if (m_wr[i]) begin
         m_mem[i][m_addr[i]]   = m_data[i];
         m_known[i][m_addr[i]] = 1;
         m_rdata[i]  = m_data[i];
         m_rknown[i] = 1;
      end else begin
         m_rdata[i]  = m_mem[i][m_addr[i]];
         m_rknown[i] = m_known[i][m_addr[i]];
      end
   endtask

   always @(posedge clk or posedge rst) begin
      for (int i = 0; i < N; i++) begin
         if (rst) begin
            m_pend[i] = 0;
            m_ack[i]  = 0;
            m_drop[i] = 0;
         end else begin
            m_drop[i] = (m_pend[i] || m_ack[i]) && (ldwr[i] === 1'b1);
            if (m_ack[i]) begin
               if (req[i] !== 1'b1) m_ack[i] = 0;
            end else if (m_pend[i]) begin
               m_left[i]--;
               if (m_left[i] == 0) m_complete(i);
            end else if (ldwr[i] === 1'b1) begin
               m_mem[i][ldaddr[i]]   = lddata[i];
               m_known[i][ldaddr[i]] = 1;
            end else if (req[i] === 1'b1) begin
               m_pend[i] = 1;
               m_wr[i]   = wr[i];
               m_addr[i] = addr[i];
               m_data[i] = wdata[i];
               m_left[i] = wc(i);
               if (m_left[i] == 0) m_complete(i);
            end
         end
      end
   end

   always @(negedge clk) begin
      if (checking) begin
         for (int i = 0; i < N; i++) begin
            chk("ack", i, 32'(ack[i]), 32'(m_ack[i]));
            chk("busy", i, 32'(busy[i]), 32'(m_pend[i] || m_ack[i]));
            chk("load_drop", i, 32'(drop[i]), 32'(m_drop[i]));
            if (rst) chk("rdata_reset", i, 32'(rdata[i]), 32'h0);
            else if (m_ack[i] && m_rknown[i]) chk("rdata", i, 32'(rdata[i]), 32'(m_rdata[i]));
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_load(input int i, input logic [4:0] a, input logic [7:0] d);
      ldwr[i] = 1'b1; ldaddr[i] = a; lddata[i] = d;
      tick();
      ldwr[i] = 1'b0;
   endtask

   // Edges are counted from the first edge that sees Req high; inputs are scrambled once latched.
   task automatic access(input int i, input logic w, input logic [4:0] a, input logic [7:0] d,
                         input int exp_edges, input logic [7:0] exp_rd, input int hold);
      int edges;
      req[i] = 1'b1; wr[i] = w; addr[i] = a; wdata[i] = d;
      edges = 0;
      while (edges < 40) begin
         @(posedge clk);
         edges++;
         #1;
         wr[i] = ~w; addr[i] = ~a; wdata[i] = ~d;
         if (ack[i] === 1'b1) break;
      end
      chk("ack_latency", i, 32'(edges), 32'(exp_edges));
      chk("ack_rdata", i, 32'(rdata[i]), 32'(exp_rd));
      for (int k = 0; k < hold; k++) begin
         tick();
         chk("ack_hold", i, 32'(ack[i]), 32'h1);
         chk("rdata_hold", i, 32'(rdata[i]), 32'(exp_rd));
      end
      req[i] = 1'b0;
      tick();
      chk("ack_release", i, 32'(ack[i]), 32'h0);
      chk("busy_release", i, 32'(busy[i]), 32'h0);
   endtask

   initial begin
      rst = 1'b1;
      for (int i = 0; i < N; i++) begin
         req[i] = 0; wr[i] = 0; addr[i] = '0; wdata[i] = '0;
         ldwr[i] = 0; ldaddr[i] = '0; lddata[i] = '0;
      end
      tick();
      checking = 1;
      tick();
      for (int i = 0; i < N; i++) begin
         chk("reset_ack", i, 32'(ack[i]), 32'h0);
         chk("reset_busy", i, 32'(busy[i]), 32'h0);
         chk("reset_drop", i, 32'(drop[i]), 32'h0);
         chk("reset_rdata", i, 32'(rdata[i]), 32'h0);
      end
      rst = 1'b0;

      // Load then read, one wait state
      do_load(0, 5'h03, 8'hA5);
      access(0, 1'b0, 5'h03, 8'h00, 2, 8'hA5, 0);

      // Write then read at the top address, no wait states
      access(1, 1'b1, 5'h1F, 8'h3C, 1, 8'h3C, 0);
      access(1, 1'b0, 5'h1F, 8'h00, 1, 8'h3C, 0);

      // Ack held for five cycles
      access(0, 1'b0, 5'h03, 8'h00, 2, 8'hA5, 5);

      // Req together with LoadWr in IDLE: load wins, request serviced afterwards
      ldwr[0] = 1'b1; ldaddr[0] = 5'h0A; lddata[0] = 8'h5A;
      req[0] = 1'b1; wr[0] = 1'b0; addr[0] = 5'h0A;
      tick();
      ldwr[0] = 1'b0;
      chk("simul_busy", 0, 32'(busy[0]), 32'h0);
      chk("simul_drop", 0, 32'(drop[0]), 32'h0);
      access(0, 1'b0, 5'h0A, 8'h00, 2, 8'h5A, 0);

      // Address 0 write/read with three wait states
      access(2, 1'b1, 5'h00, 8'hC3, 4, 8'hC3, 2);
      access(2, 1'b0, 5'h00, 8'h00, 4, 8'hC3, 0);

      // Reset in the second WAIT cycle aborts a pending write
      do_load(2, 5'h05, 8'h11);
      req[2] = 1'b1; wr[2] = 1'b1; addr[2] = 5'h05; wdata[2] = 8'h77;
      tick();
      tick();
      chk("mid_wait_busy", 2, 32'(busy[2]), 32'h1);
      rst = 1'b1;
      #1;
      chk("abort_busy", 2, 32'(busy[2]), 32'h0);
      chk("abort_ack", 2, 32'(ack[2]), 32'h0);
      chk("abort_rdata", 2, 32'(rdata[2]), 32'h0);
      req[2] = 1'b0; wr[2] = 1'b0;
      tick();
      rst = 1'b0;
      access(2, 1'b0, 5'h05, 8'h00, 4, 8'h11, 0);

      // LoadWr during WAIT and during ACK is dropped
      req[2] = 1'b1; wr[2] = 1'b0; addr[2] = 5'h05;
      tick();
      ldwr[2] = 1'b1; ldaddr[2] = 5'h05; lddata[2] = 8'hEE;
      tick();
      ldwr[2] = 1'b0;
      chk("drop_wait_pulse", 2, 32'(drop[2]), 32'h1);
      tick();
      chk("drop_wait_clear", 2, 32'(drop[2]), 32'h0);
      tick();
      chk("drop_ack", 2, 32'(ack[2]), 32'h1);
      chk("drop_rdata", 2, 32'(rdata[2]), 32'h11);
      ldwr[2] = 1'b1; ldaddr[2] = 5'h05; lddata[2] = 8'hEE;
      tick();
      ldwr[2] = 1'b0;
      chk("drop_ack_pulse", 2, 32'(drop[2]), 32'h1);
      req[2] = 1'b0;
      tick();
      chk("drop_ack_clear", 2, 32'(drop[2]), 32'h0);
      access(2, 1'b0, 5'h05, 8'h00, 4, 8'h11, 0);

      tick();
      checking = 0;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 Parameters SHALL be, one per line:
- ADDR_W, 5, address width
- DATA_W, 8, data width
- WAIT_CYCLES, 1, extra wait states per access, legal range 0..15
REQ-002 Ports SHALL be, one per line (clock and reset first):
- Clk  in  1  single clock; all state updates on the rising edge
- Reset  in  1  asynchronous, active-high reset
- Req  in  1  CPU access request, held until Ack
- Wr  in  1  1 = write, 0 = read; qualified by Req
- Addr  in  ADDR_W  access address
- WData  in  DATA_W  write data
- RData  out  DATA_W  read data, valid while Ack = 1
- Ack  out  1  access complete
- Busy  out  1  high in any state other than IDLE
- LoadWr  in  1  single-cycle program-load write strobe
- LoadAddr  in  ADDR_W  load address
- LoadData  in  DATA_W  load data
- LoadDrop  out  1  one-cycle pulse when a LoadWr is rejected

Function
REQ-003 The FSM SHALL have states IDLE, WAIT and ACK, with a 4-phase Req/Ack handshake.
REQ-004 In IDLE with LoadWr = 1, the block SHALL write LoadData to LoadAddr at that edge and remain in IDLE; Req SHALL be ignored that cycle.
REQ-005 In IDLE with LoadWr = 0 and Req = 1, the block SHALL latch Wr, Addr and WData at that edge.
- It SHALL then enter WAIT if WAIT_CYCLES > 0, otherwise ACK.
REQ-006 In WAIT, a down-counter SHALL count WAIT_CYCLES cycles; on expiry the block SHALL enter ACK.
- Ack SHALL rise exactly 1 + WAIT_CYCLES edges after the edge that sampled Req.
REQ-007 A latched write SHALL commit to the array on the edge entering ACK.
- A latched read SHALL register the array word on that same edge into RData.
REQ-008 In ACK, Ack SHALL stay 1 and RData SHALL stay stable until Req is sampled 0; the block SHALL then return to IDLE with Ack = 0 at that edge.
REQ-009 Changes to Addr, Wr or WData after the request is latched SHALL have no effect on the access.
REQ-010 LoadWr in WAIT or ACK SHALL NOT write the array and SHALL pulse LoadDrop for exactly one cycle.
REQ-011 For a write access, RData SHALL present the written data during ACK.
REQ-012 Busy SHALL be 0 only in IDLE.
REQ-013 Addresses SHALL be full-range, with no wrap logic: the array holds 2**ADDR_W words.

Reset
REQ-014 Reset SHALL force IDLE and clear all outputs to 0: Ack, Busy, LoadDrop, RData.
- It SHALL also clear the wait counter and the latched request.
REQ-015 Reset asserted during WAIT SHALL abort the access; a pending write SHALL NOT commit.
REQ-016 Array contents SHALL NOT be cleared by Reset.
REQ-017 After Reset deasserts, the first Req SHALL be sampled on the first rising edge.

Structure
REQ-018 Package cu_pkg SHALL hold the state enum mem_state_t (IDLE, WAIT, ACK) and the default ADDR_W/DATA_W constants.
- The existing control unit SHALL share this package.
REQ-019 The storage SHALL be a sub-module ram_array: one synchronous write port, one registered read, no reset.
REQ-020 The FSM, wait counter and load arbitration SHALL reside in mem_responder.

Verification
REQ-021 Load then read, WAIT_CYCLES = 1: LoadWr at addr 0x03 with data 0xA5, then read Req at 0x03 -> Ack rises 2 edges after Req is sampled, RData = 0xA5.
REQ-022 Write then read, WAIT_CYCLES = 0: write 0x3C to 0x1F -> Ack one edge later, RData = 0x3C; a following read of 0x1F -> 0x3C.
REQ-023 Ack hold: Req held 5 cycles after Ack -> Ack stays high for all 5 cycles with RData stable, then drops on the edge that samples Req = 0.
REQ-024 Simultaneous Req and LoadWr in IDLE: load commits, Req is serviced next cycle, LoadDrop = 0; a LoadWr during WAIT -> LoadDrop single pulse and the array is unchanged.
REQ-025 Reset mid-WAIT, WAIT_CYCLES = 3: write 0x77 to 0x05, Reset in the second WAIT cycle -> outputs 0, state IDLE; a later read of 0x05 returns its prior value.
